// File: rtl/fma16_normround.sv
`default_nettype none
// ============================================================================
// fma16_normround : fma16 normalise/round stage (LZC+shift, then round+pack)
// Option macro    : FMA16_SUBNORM_EN (gradual underflow; default flushes)
// Revision        : 1.0
// ============================================================================
module fma16_normround (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [33:0] Sm,
   input  logic [6:0]  Se,
   input  logic        Ss,
   input  logic        Sticky,
   input  logic [1:0]  roundmode,
   input  logic        Special,
   input  logic [15:0] SpecialRes,
   input  logic [3:0]  SpecialFlg,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic [3:0]  flags
);

   localparam logic [1:0] c_RNE = 2'b00;
   localparam logic [1:0] c_RZ  = 2'b01;
   localparam logic [1:0] c_RM  = 2'b10;
   localparam logic [1:0] c_RP  = 2'b11;

   logic        r1_valid, r2_valid;
   logic        w_adv;

   assign w_adv     = ~r2_valid | out_ready;
   assign in_ready  = ~r1_valid | w_adv;
   assign out_valid = r2_valid;

   // ---------------- S1: leading-one detect and normalise ----------------
   logic [5:0]  w_lead;
   logic [5:0]  w_shamt;
   logic [33:0] w_norm;
   logic [7:0]  w_exp1;
   logic        w_smzero;

   always_comb begin
      w_lead = 6'd0;
      for (int i = 0; i < 34; i++)
         if (Sm[i]) w_lead = 6'(i);
   end

   assign w_smzero = ~|Sm;
   assign w_shamt  = 6'd33 - w_lead;
   assign w_norm   = Sm << w_shamt;
   // Sticky-only sums get a hopelessly small exponent so they take the tiny path
   assign w_exp1   = w_smzero ? 8'h80
                              : ({Se[6], Se} + {2'b00, w_lead} - 8'd22);

   logic [11:0] r1_sig;
   logic        r1_stk;
   logic [7:0]  r1_exp;
   logic        r1_sign;
   logic        r1_zero;
   logic [1:0]  r1_rm;
   logic        r1_special;
   logic [15:0] r1_spres;
   logic [3:0]  r1_spflg;

   // ---------------- S2: round and pack ----------------
   logic        w_tiny;
   logic [10:0] w_sig;
   logic        w_g, w_s, w_lsb, w_up, w_inx, w_away, w_inf;
   logic [11:0] w_sum;
   logic [7:0]  w_exp_r;
   logic [15:0] w_res;
   logic [3:0]  w_flg;

   assign w_tiny = $signed(r1_exp) <= 8'sd0;

`ifdef FMA16_SUBNORM_EN
   logic [7:0]  w_dsh;
   logic [23:0] w_den;

   always_comb begin
      w_dsh = 8'd0;
      if (w_tiny)
         w_dsh = ((8'd1 - r1_exp) > 8'd12) ? 8'd12 : (8'd1 - r1_exp);
   end

   assign w_den = {r1_sig, 12'd0} >> w_dsh;
   assign w_sig = w_den[23:13];
   assign w_g   = w_den[12];
   assign w_s   = (|w_den[11:0]) | r1_stk;
`else
   assign w_sig = r1_sig[11:1];
   assign w_g   = r1_sig[0];
   assign w_s   = r1_stk;
`endif

   assign w_lsb = w_sig[0];
   assign w_inx = w_g | w_s;

   always_comb begin
      w_up = 1'b0;
      case (r1_rm)
         c_RNE:   w_up = w_g & (w_s | w_lsb);
         c_RZ:    w_up = 1'b0;
         c_RM:    w_up = r1_sign & w_inx;
         c_RP:    w_up = ~r1_sign & w_inx;
         default: w_up = 1'b0;
      endcase
   end

   assign w_sum   = {1'b0, w_sig} + {11'd0, w_up};
   // Integer part of the rounded significand is 1 or 2 (mantissa carry-out)
   assign w_exp_r = r1_exp - 8'd1 + {6'd0, w_sum[11:10]};
   assign w_away  = ((r1_rm == c_RM) & r1_sign) | ((r1_rm == c_RP) & ~r1_sign);
   assign w_inf   = (r1_rm == c_RNE) | w_away;

   always_comb begin
      w_res = {r1_sign, w_exp_r[4:0], w_sum[9:0]};
      w_flg = {3'b000, w_inx};
      if (r1_special) begin
         w_res = r1_spres;
         w_flg = r1_spflg;
      end else if (r1_zero) begin
         w_res = (r1_rm == c_RM) ? 16'h8000 : 16'h0000;
         w_flg = 4'b0000;
      end else if (w_tiny) begin
`ifdef FMA16_SUBNORM_EN
         w_res = {r1_sign, 4'b0000, w_sum[10:0]};
         w_flg = {2'b00, w_inx, w_inx};
`else
         w_res = {r1_sign, (w_away ? 15'h0400 : 15'h0000)};
         w_flg = 4'b0011;
`endif
      end else if ($signed(w_exp_r) >= 8'sd31) begin
         w_res = {r1_sign, (w_inf ? 15'h7C00 : 15'h7BFF)};
         w_flg = 4'b0101;
      end
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r1_valid   <= 1'b0;
         r2_valid   <= 1'b0;
         r1_sig     <= 12'd0;
         r1_stk     <= 1'b0;
         r1_exp     <= 8'd0;
         r1_sign    <= 1'b0;
         r1_zero    <= 1'b0;
         r1_rm      <= 2'b00;
         r1_special <= 1'b0;
         r1_spres   <= 16'h0000;
         r1_spflg   <= 4'h0;
         result     <= 16'h0000;
         flags      <= 4'h0;
      end else begin
         if (in_ready) begin
            r1_valid <= in_valid;
            if (in_valid) begin
               r1_sig     <= w_norm[33:22];
               r1_stk     <= (|w_norm[21:0]) | Sticky;
               r1_exp     <= w_exp1;
               r1_sign    <= Ss;
               r1_zero    <= w_smzero & ~Sticky;
               r1_rm      <= roundmode;
               r1_special <= Special;
               r1_spres   <= SpecialRes;
               r1_spflg   <= SpecialFlg;
            end
         end
         if (w_adv) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
               result <= w_res;
               flags  <= w_flg;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fma16_normround.sv
`default_nettype none
// Directed bench for fma16_normround: rounding modes, overflow, zero, flush-to-zero,
// specials, reset behaviour and back-pressure ordering.
module tb_fma16_normround;

   localparam logic [1:0] RNE = 2'b00;
   localparam logic [1:0] RZ  = 2'b01;
   localparam logic [1:0] RM  = 2'b10;
   localparam logic [1:0] RP  = 2'b11;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [33:0] Sm;
   logic [6:0]  Se;
   logic        Ss;
   logic        Sticky;
   logic [1:0]  roundmode;
   logic        Special;
   logic [15:0] SpecialRes;
   logic [3:0]  SpecialFlg;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  flags;

   int          checks = 0;
   int          errors = 0;
   int          lat;
   logic [15:0] got_res;
   logic [3:0]  got_flg;

   fma16_normround dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .Sm         (Sm),
      .Se         (Se),
      .Ss         (Ss),
      .Sticky     (Sticky),
      .roundmode  (roundmode),
      .Special    (Special),
      .SpecialRes (SpecialRes),
      .SpecialFlg (SpecialFlg),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .flags      (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present the current inputs, wait for acceptance and for the result.
   task automatic issue();
      int n;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      n = 0;
      #1;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("out_valid_seen", {15'd0, out_valid}, 16'h0001);
      got_res = result;
      got_flg = flags;
   endtask

   task automatic op(input logic [33:0] sm, input logic [6:0] se, input logic ss,
                     input logic stk, input logic [1:0] rm);
      Sm = sm; Se = se; Ss = ss; Sticky = stk; roundmode = rm; Special = 1'b0;
      issue();
   endtask

   task automatic expect_out(input string tag, input logic [15:0] er, input logic [3:0] ef);
      chk({tag, "_res"}, got_res, er);
      chk({tag, "_flg"}, {12'd0, got_flg}, {12'd0, ef});
   endtask

   logic [15:0] q_exp [4];
   logic [6:0]  q_se  [4];
   int          send, recv;
   logic        seen;

   initial begin
      q_exp = '{16'h3C00, 16'h4000, 16'h4400, 16'h4800};
      q_se  = '{7'd15, 7'd16, 7'd17, 7'd18};
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      Sm = '0; Se = '0; Ss = 1'b0; Sticky = 1'b0; roundmode = RNE;
      Special = 1'b0; SpecialRes = '0; SpecialFlg = '0;
      #1;
      chk("rst_out_valid", {15'd0, out_valid}, 16'h0000);
      chk("rst_result", result, 16'h0000);
      chk("rst_flags", {12'd0, flags}, 16'h0000);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("rst_in_ready", {15'd0, in_ready}, 16'h0001);

      // Basic 1.0 and latency
      op(34'h000400000, 7'd15, 1'b0, 1'b0, RNE);
      chk("one_latency", 16'(lat), 16'd1);
      expect_out("one", 16'h3C00, 4'b0000);

      // Ties and rounding
      op(34'h000400800, 7'd15, 1'b0, 1'b0, RNE); expect_out("tie_even", 16'h3C00, 4'b0001);
      op(34'h000401800, 7'd15, 1'b0, 1'b0, RNE); expect_out("tie_odd",  16'h3C02, 4'b0001);
      op(34'h000401800, 7'd15, 1'b0, 1'b0, RP);  expect_out("tie_rp",   16'h3C02, 4'b0001);
      op(34'h000400000, 7'd15, 1'b0, 1'b1, RP);  expect_out("stk_rp",   16'h3C01, 4'b0001);
      op(34'h000400000, 7'd15, 1'b0, 1'b1, RNE); expect_out("stk_rne",  16'h3C00, 4'b0001);
      op(34'h000400000, 7'd15, 1'b1, 1'b1, RM);  expect_out("stk_rm",   16'hBC01, 4'b0001);
      op(34'h0007FF800, 7'd15, 1'b0, 1'b0, RNE); expect_out("carry",    16'h4000, 4'b0001);

      // Normalisation in both directions
      op(34'h000800000, 7'd15, 1'b0, 1'b0, RNE); expect_out("norm_two",  16'h4000, 4'b0000);
      op(34'h000100000, 7'd15, 1'b0, 1'b0, RNE); expect_out("norm_qtr",  16'h3400, 4'b0000);
      op(34'h200000000, 7'd4,  1'b0, 1'b0, RZ);  expect_out("norm_top",  16'h3C00, 4'b0000);

      // Overflow
      op(34'h000400000, 7'd31, 1'b0, 1'b0, RNE); expect_out("ovf_rne", 16'h7C00, 4'b0101);
      op(34'h000400000, 7'd31, 1'b0, 1'b0, RZ);  expect_out("ovf_rz",  16'h7BFF, 4'b0101);
      op(34'h000400000, 7'd31, 1'b1, 1'b0, RP);  expect_out("ovf_rp_neg", 16'hFBFF, 4'b0101);
      op(34'h000400000, 7'd31, 1'b1, 1'b0, RM);  expect_out("ovf_rm_neg", 16'hFC00, 4'b0101);
      op(34'h0007FF800, 7'd30, 1'b0, 1'b0, RNE); expect_out("ovf_round", 16'h7C00, 4'b0101);

      // Exact zero
      op(34'h0, 7'd15, 1'b0, 1'b0, RNE); expect_out("zero_rne", 16'h0000, 4'b0000);
      op(34'h0, 7'd15, 1'b0, 1'b0, RM);  expect_out("zero_rm",  16'h8000, 4'b0000);

      // Underflow with flush (default build)
      op(34'h000400000, 7'h7E, 1'b0, 1'b0, RNE); expect_out("unf_rne", 16'h0000, 4'b0011);
      op(34'h000400000, 7'h7E, 1'b0, 1'b0, RP);  expect_out("unf_rp",  16'h0400, 4'b0011);
      op(34'h000400000, 7'h7E, 1'b1, 1'b0, RM);  expect_out("unf_rm",  16'h8400, 4'b0011);
      op(34'h0, 7'd15, 1'b0, 1'b1, RNE);         expect_out("stk_only", 16'h0000, 4'b0011);

      // Special bypass
      Sm = 34'h000400000; Se = 7'd15; Ss = 1'b0; Sticky = 1'b0; roundmode = RNE;
      Special = 1'b1; SpecialRes = 16'h7E00; SpecialFlg = 4'b1000;
      issue();
      Special = 1'b0;
      chk("special_latency", 16'(lat), 16'd1);
      expect_out("special", 16'h7E00, 4'b1000);

      // Reset while an entry is in flight
      Sm = 34'h000400000; Se = 7'd15; out_ready = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("midrst_valid", {15'd0, out_valid}, 16'h0000);
      chk("midrst_result", result, 16'h0000);
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_output", {15'd0, seen}, 16'h0000);
      op(34'h000401800, 7'd15, 1'b0, 1'b0, RNE); expect_out("post_rst", 16'h3C02, 4'b0001);

      // Back-pressure: four back-to-back, downstream stalled for three observed cycles
      @(posedge clk); #1;
      Sm = 34'h000400000; Ss = 1'b0; Sticky = 1'b0; roundmode = RNE; Special = 1'b0;
      send = 0; recv = 0;
      for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 5);
         if (send < 4) begin
            in_valid = 1'b1;
            Se = q_se[send];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc >= 2 && cyc <= 4) begin
            chk("stall_in_ready", {15'd0, in_ready}, 16'h0000);
            chk("stall_valid", {15'd0, out_valid}, 16'h0001);
            chk("stall_hold", result, 16'h3C00);
         end
         if (cyc == 4) chk("stall_accepts", 16'(send), 16'd2);
         if (out_valid && out_ready) begin
            chk("order", result, q_exp[recv]);
            recv++;
         end
         if (in_valid && in_ready) send++;
      end
      in_valid = 1'b0;
      chk("drained", 16'(recv), 16'd4);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("no_duplicate", {15'd0, seen}, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
